// File: rtl/tt_um_sjsu_vga.sv
// ============================================================================
// Module  : tt_um_sjsu_vga
// Brief   : 640x480@60 VGA generator (25 MHz) drawing a bouncing SJSU-gold
//           64x64 box on blue for the TinyVGA Pmod. Define SJSU_BORDER_EN
//           to add a white one-pixel frame around the active area.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tt_um_sjsu_vga (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_TOTAL  = 10'd800;
    localparam logic [9:0] HS_START = 10'd656;
    localparam logic [9:0] HS_END   = 10'd751;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_TOTAL  = 10'd525;
    localparam logic [9:0] VS_START = 10'd490;
    localparam logic [9:0] VS_END   = 10'd491;
    localparam logic [9:0] BOX_SIZE = 10'd64;
    localparam logic [9:0] BX_MAX   = 10'd576;
    localparam logic [8:0] BY_MAX   = 9'd416;
    localparam logic [5:0] GOLD_RGB = 6'b11_10_00;
    localparam logic [5:0] BLUE_RGB = 6'b00_00_10;

    logic [9:0] h_q, h_d, v_q, v_d, bx_q, bx_d;
    logic [8:0] by_q, by_d;
    logic       dx_q, dx_d, dy_q, dy_d;
    logic [7:0] uo_q, uo_d;

    logic       invert, pause;
    logic       active, in_box, hsync, vsync;
    logic [9:0] by_ext;
    logic [5:0] rgb;

    assign invert = ui_in[0];
    assign pause  = ui_in[1];
    assign by_ext = {1'b0, by_q};

    always_comb begin
        h_d  = h_q;
        v_d  = v_q;
        bx_d = bx_q;
        by_d = by_q;
        dx_d = dx_q;
        dy_d = dy_q;

        if (h_q == H_TOTAL - 10'd1) begin
            h_d = 10'd0;
            v_d = (v_q == V_TOTAL - 10'd1) ? 10'd0 : v_q + 10'd1;
        end else begin
            h_d = h_q + 10'd1;
        end

        // Move once per frame just after the last visible line, so a new
        // position is never shown partway through a frame.
        if (h_q == 10'd0 && v_q == V_ACTIVE && !pause) begin
            if (dx_q && bx_q == BX_MAX) begin
                dx_d = 1'b0;
                bx_d = BX_MAX - 10'd1;
            end else if (!dx_q && bx_q == 10'd0) begin
                dx_d = 1'b1;
                bx_d = 10'd1;
            end else begin
                bx_d = dx_q ? bx_q + 10'd1 : bx_q - 10'd1;
            end

            if (dy_q && by_q == BY_MAX) begin
                dy_d = 1'b0;
                by_d = BY_MAX - 9'd1;
            end else if (!dy_q && by_q == 9'd0) begin
                dy_d = 1'b1;
                by_d = 9'd1;
            end else begin
                by_d = dy_q ? by_q + 9'd1 : by_q - 9'd1;
            end
        end
    end

    always_comb begin
        active = (h_q < H_ACTIVE) && (v_q < V_ACTIVE);
        in_box = (h_q >= bx_q) && (h_q < bx_q + BOX_SIZE) &&
                 (v_q >= by_ext) && (v_q < by_ext + BOX_SIZE);
        hsync  = !((h_q >= HS_START) && (h_q <= HS_END));
        vsync  = !((v_q >= VS_START) && (v_q <= VS_END));

        rgb = in_box ? GOLD_RGB : BLUE_RGB;
`ifdef SJSU_BORDER_EN
        if (h_q == 10'd0 || h_q == H_ACTIVE - 10'd1 ||
            v_q == 10'd0 || v_q == V_ACTIVE - 10'd1) begin
            rgb = 6'b11_11_11;
        end
`endif
        if (invert) begin
            rgb = ~rgb;
        end
        if (!active) begin
            rgb = 6'b00_00_00;
        end

        // rgb is {R1,R0,G1,G0,B1,B0}; TinyVGA splits MSBs and LSBs by nibble.
        uo_d = {hsync, rgb[0], rgb[2], rgb[4], vsync, rgb[1], rgb[3], rgb[5]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q  <= 10'd0;
            v_q  <= 10'd0;
            bx_q <= 10'd0;
            by_q <= 9'd0;
            dx_q <= 1'b1;
            dy_q <= 1'b1;
            uo_q <= 8'b1000_1000;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            bx_q <= bx_d;
            by_q <= by_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
            uo_q <= uo_d;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:2]};

endmodule

`default_nettype wire

// File: tb/tb_tt_um_sjsu_vga.sv
// ============================================================================
// Module  : tb_tt_um_sjsu_vga
// Brief   : Directed bench for tt_um_sjsu_vga (default build, no border).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tt_um_sjsu_vga;

    localparam logic [7:0] GOLD  = 8'h9B;
    localparam logic [7:0] BLUE  = 8'h8C;
    localparam logic [7:0] IBLUE = 8'hFB;
    localparam logic [7:0] HBLNK = 8'h08;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int total;
    int bad;
    int n;
    logic [9:0] jh;
    logic [9:0] jv;

    tt_um_sjsu_vga dut (
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe),
        .ena    (ena),
        .clk    (clk),
        .rst_n  (rst_n)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; uo_out then shows the pixel the counters held before it.
    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic run_to(input int target);
        while (n < target) tick();
    endtask

    // Load the pixel counters so the next clock registers pixel (h,v).
    task automatic jump(input logic [9:0] h, input logic [9:0] v);
        @(negedge clk);
        jh = h;
        jv = v;
        force dut.h_q = jh;
        force dut.v_q = jv;
        #1;
        release dut.h_q;
        release dut.v_q;
    endtask

    task automatic show(input logic [9:0] h, input logic [9:0] v);
        jump(h, v);
        tick();
    endtask

    // Compressed frame: end of line 479, then the motion-update clock.
    task automatic frame_step();
        jump(10'd799, 10'd479);
        tick();
        tick();
    endtask

    initial begin
        int lo;
        int guard;
        total = 0;
        bad   = 0;
        n     = 0;
        jh    = '0;
        jv    = '0;
        rst_n = 1'b0;
        ena   = 1'b1;
        ui_in = 8'h00;
        uio_in = 8'h00;

        #100;
        chk("reset_uo_out", {24'd0, uo_out}, 32'h88);
        chk("reset_uio_out", {24'd0, uio_out}, 32'h00);
        chk("reset_uio_oe", {24'd0, uio_oe}, 32'h00);
        #100;
        rst_n = 1'b1;

        guard = 0;
        tick();
        while (uo_out[7] !== 1'b0 && guard < 1000) begin tick(); guard++; end
        chk("hsync_first_fall", n, 657);
        lo = 0;
        while (uo_out[7] === 1'b0 && lo < 200) begin lo++; tick(); end
        chk("hsync_low_width", lo, 96);
        guard = 0;
        while (uo_out[7] !== 1'b0 && guard < 1000) begin tick(); guard++; end
        chk("hsync_second_fall", n, 1457);

        run_to(10*800 + 10 + 1);
        chk("box_10_10", {24'd0, uo_out}, {24'd0, GOLD});
        run_to(10*800 + 63 + 1);
        chk("box_edge_63_10", {24'd0, uo_out}, {24'd0, GOLD});
        tick();
        chk("bg_64_10", {24'd0, uo_out}, {24'd0, BLUE});
        run_to(10*800 + 100 + 1);
        chk("bg_100_10", {24'd0, uo_out}, {24'd0, BLUE});
        run_to(10*800 + 700 + 1);
        chk("blank_700_10", {24'd0, uo_out}, {24'd0, HBLNK});

        run_to(11*800 + 100);
        ui_in = 8'h01;
        tick();
        chk("inv_bg_100_11", {24'd0, uo_out}, {24'd0, IBLUE});
        run_to(11*800 + 700 + 1);
        chk("inv_blank_700_11", {24'd0, uo_out}, {24'd0, HBLNK});
        run_to(12*800 + 10);
        ui_in = 8'h00;
        tick();
        chk("uninv_box_10_12", {24'd0, uo_out}, {24'd0, GOLD});

        jump(10'd799, 10'd489);
        tick();
        chk("vsync_high_489", {31'd0, uo_out[3]}, 32'd1);
        lo = 0;
        tick();
        while (uo_out[3] === 1'b0 && lo < 2000) begin lo++; tick(); end
        chk("vsync_low_width", lo, 1600);

        repeat (3) frame_step();
        show(10'd3, 10'd3);   chk("f3_box_3_3", {24'd0, uo_out}, {24'd0, GOLD});
        show(10'd2, 10'd3);   chk("f3_bg_2_3", {24'd0, uo_out}, {24'd0, BLUE});
        show(10'd3, 10'd2);   chk("f3_bg_3_2", {24'd0, uo_out}, {24'd0, BLUE});
        show(10'd66, 10'd66); chk("f3_box_66_66", {24'd0, uo_out}, {24'd0, GOLD});
        show(10'd67, 10'd66); chk("f3_bg_67_66", {24'd0, uo_out}, {24'd0, BLUE});
        show(10'd66, 10'd67); chk("f3_bg_66_67", {24'd0, uo_out}, {24'd0, BLUE});

        ui_in = 8'h02;
        repeat (3) frame_step();
        ui_in = 8'h00;
        show(10'd3, 10'd3);   chk("paused_box_3_3", {24'd0, uo_out}, {24'd0, GOLD});
        show(10'd2, 10'd3);   chk("paused_bg_2_3", {24'd0, uo_out}, {24'd0, BLUE});

        // 576 moves in total: bx=576 (dx=1), by has bounced at 416 down to 256.
        repeat (573) frame_step();
        show(10'd576, 10'd300); chk("bx576_box", {24'd0, uo_out}, {24'd0, GOLD});
        show(10'd575, 10'd300); chk("bx576_bg", {24'd0, uo_out}, {24'd0, BLUE});
        show(10'd639, 10'd300); chk("bx576_right", {24'd0, uo_out}, {24'd0, GOLD});
        frame_step();
        show(10'd575, 10'd300); chk("bx575_box", {24'd0, uo_out}, {24'd0, GOLD});
        show(10'd639, 10'd300); chk("bx575_right_bg", {24'd0, uo_out}, {24'd0, BLUE});
        frame_step();
        show(10'd574, 10'd300); chk("bx574_box", {24'd0, uo_out}, {24'd0, GOLD});
        show(10'd638, 10'd300); chk("bx574_right_bg", {24'd0, uo_out}, {24'd0, BLUE});

        // 574 more moves: bx reaches 0; by bounced at 0 and climbed to 320.
        repeat (574) frame_step();
        show(10'd0, 10'd330);  chk("bx0_box", {24'd0, uo_out}, {24'd0, GOLD});
        show(10'd64, 10'd330); chk("bx0_bg", {24'd0, uo_out}, {24'd0, BLUE});
        show(10'd10, 10'd319); chk("by320_above", {24'd0, uo_out}, {24'd0, BLUE});
        show(10'd10, 10'd320); chk("by320_top", {24'd0, uo_out}, {24'd0, GOLD});
        frame_step();
        show(10'd0, 10'd330);  chk("bx1_left_bg", {24'd0, uo_out}, {24'd0, BLUE});
        show(10'd1, 10'd330);  chk("bx1_box", {24'd0, uo_out}, {24'd0, GOLD});
        show(10'd64, 10'd330); chk("bx1_right", {24'd0, uo_out}, {24'd0, GOLD});
        show(10'd10, 10'd320); chk("by321_above", {24'd0, uo_out}, {24'd0, BLUE});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
